// File: rtl/pwm_fade_if.sv
// pwm_fade_if: fade-command handshake between a command source and pwm_fade_ctrl.
//   cfg_valid  : source has a command (target duty, step) on the bus
//   cfg_ready  : controller can accept a command this cycle
//   cfg_target : requested final duty (DW bits)
//   cfg_step   : duty change per PWM period (STEP_W bits)
// Modports: master = command source, slave = controller.
interface pwm_fade_if #(
  parameter int DW     = 8,
  parameter int STEP_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DW-1:0]     cfg_target;
  logic [STEP_W-1:0] cfg_step;

  modport master (output cfg_valid, output cfg_target, output cfg_step, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_target, input cfg_step, output cfg_ready);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: duty-cycle sequencer feeding the duty input of a PWM generator.
// A fade command (target, step) is accepted over the cfg handshake; the duty
// output then ramps toward the target by one step per PWM period, advancing
// only on the generator's period-boundary pulse.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cfg          : pwm_fade_if.slave command handshake
//   pwm_cyc_end  : one-cycle pulse at each PWM period boundary
//   duty         : registered duty to the PWM generator
//   duty_load    : high in the first cycle a new duty value is visible
//   busy         : ramp in progress
//   done         : one-cycle pulse when a fade completes
// Optional build macro PWM_FADE_BREATHE_EN: an upward ramp that reaches a
// non-zero target turns around and ramps back down to 0 ("breath"); done
// pulses only when duty returns to 0.
module pwm_fade_ctrl #(
  parameter int PERIOD = 100,
  parameter int DW     = 8,
  parameter int STEP_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_fade_if.slave     cfg,
  input  logic          pwm_cyc_end,
  output logic [DW-1:0] duty,
  output logic          duty_load,
  output logic          busy,
  output logic          done
);

  // Arithmetic width wide enough that duty+step and target+step never wrap.
  localparam int AW = ((DW > STEP_W) ? DW : STEP_W) + 1;
  localparam logic [DW-1:0] PERIOD_V = DW'(PERIOD);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     duty_reg, duty_next;
  logic [DW-1:0]     tgt_reg, tgt_next;
  logic [STEP_W-1:0] stp_reg, stp_next;
  logic              done_reg, done_next;
  logic              duty_load_reg, duty_load_next;
  logic              ready_int;

  logic [AW-1:0]     up_sum, dn_lim;
  logic [DW-1:0]     up_val, dn_val;
  logic [DW-1:0]     cmd_tgt;
  logic [STEP_W-1:0] cmd_stp;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      duty_reg      <= '0;
      tgt_reg       <= '0;
      stp_reg       <= '0;
      done_reg      <= 1'b0;
      duty_load_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      duty_reg      <= duty_next;
      tgt_reg       <= tgt_next;
      stp_reg       <= stp_next;
      done_reg      <= done_next;
      duty_load_reg <= duty_load_next;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next     = state_reg;
    duty_next      = duty_reg;
    tgt_next       = tgt_reg;
    stp_next       = stp_reg;
    done_next      = 1'b0;
    duty_load_next = 1'b0;

    // Step candidates; both clamp to the target so the ramp never overshoots.
    up_sum = AW'(duty_reg) + AW'(stp_reg);
    up_val = (up_sum >= AW'(tgt_reg)) ? tgt_reg : up_sum[DW-1:0];
    dn_lim = AW'(tgt_reg) + AW'(stp_reg);
    dn_val = (AW'(duty_reg) <= dn_lim) ? tgt_reg : DW'(AW'(duty_reg) - AW'(stp_reg));

    // Command sanitising: clamp target to the period, treat step 0 as 1.
    cmd_tgt = (cfg.cfg_target > PERIOD_V) ? PERIOD_V : cfg.cfg_target;
    cmd_stp = (cfg.cfg_step == '0) ? STEP_W'(1) : cfg.cfg_step;

    case (state_reg)
      IDLE: begin
        // pwm_cyc_end deliberately ignored here, even in the accept cycle.
        if (cfg.cfg_valid && ready_int) begin
          tgt_next = cmd_tgt;
          stp_next = cmd_stp;
          if (cmd_tgt > duty_reg)      state_next = RAMP_UP;
          else if (cmd_tgt < duty_reg) state_next = RAMP_DN;
          else                         done_next  = 1'b1;
        end
      end
      RAMP_UP: begin
        if (pwm_cyc_end) begin
          duty_next      = up_val;
          duty_load_next = 1'b1;
          if (up_val == tgt_reg) begin
`ifdef PWM_FADE_BREATHE_EN
            if (tgt_reg != '0) begin
              tgt_next   = '0;
              state_next = RAMP_DN;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end
      RAMP_DN: begin
        if (pwm_cyc_end) begin
          duty_next      = dn_val;
          duty_load_next = 1'b1;
          if (dn_val == tgt_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ready_int = (state_reg == IDLE) && !rst;
    busy      = (state_reg != IDLE);
  end

  assign cfg.cfg_ready = ready_int;
  assign duty          = duty_reg;
  assign duty_load     = duty_load_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed plus randomized fades checked against a
// closed-form model of the expected duty sequence (k-th step value is the
// start duty +/- k*step, clamped to the target).
module tb_pwm_fade_ctrl;
  localparam int PERIOD = 100;
  localparam int DW     = 8;
  localparam int STEP_W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_cyc_end = 1'b0;
  logic [DW-1:0] duty;
  logic          duty_load, busy, done;

  pwm_fade_if #(.DW(DW), .STEP_W(STEP_W)) cfg_if ();

  pwm_fade_ctrl #(.PERIOD(PERIOD), .DW(DW), .STEP_W(STEP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_if),
    .pwm_cyc_end (pwm_cyc_end),
    .duty        (duty),
    .duty_load   (duty_load),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_duty = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it through every expected step.
  // abort_at != 0 stops after that many duty steps (ramp left running).
  task automatic run_fade(input int target, input int step, input int gap,
                          input bit pulse_at_accept, input int abort_at);
    int tgt, stp, n, v;
    int seq[$];
    bit last;
    tgt = (target > PERIOD) ? PERIOD : target;
    stp = (step == 0) ? 1 : step;

    check("ready_before_cmd", cfg_if.cfg_ready, 1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_target = DW'(target);
    cfg_if.cfg_step   = STEP_W'(step);
    pwm_cyc_end       = pulse_at_accept;
    tick();
    cfg_if.cfg_valid = 1'b0;
    pwm_cyc_end      = 1'b0;

    if (tgt > model_duty) begin
      n = (tgt - model_duty + stp - 1) / stp;
      for (int k = 1; k <= n; k++) begin
        v = model_duty + k * stp;
        seq.push_back((v > tgt) ? tgt : v);
      end
`ifdef PWM_FADE_BREATHE_EN
      n = (tgt + stp - 1) / stp;
      for (int k = 1; k <= n; k++) begin
        v = tgt - k * stp;
        seq.push_back((v < 0) ? 0 : v);
      end
`endif
    end else if (tgt < model_duty) begin
      n = (model_duty - tgt + stp - 1) / stp;
      for (int k = 1; k <= n; k++) begin
        v = model_duty - k * stp;
        seq.push_back((v < tgt) ? tgt : v);
      end
    end

    if (seq.size() == 0) begin
      check("eq_done", done, 1);
      check("eq_no_load", duty_load, 0);
      check("eq_busy", busy, 0);
      check("eq_duty", duty, model_duty);
      tick();
      check("eq_done_clear", done, 0);
      $display("fade tgt=%0d stp=%0d: no-op, duty=%0d", tgt, stp, duty);
      return;
    end

    check("accept_busy", busy, 1);
    check("accept_ready", cfg_if.cfg_ready, 0);
    check("accept_duty", duty, model_duty);
    check("accept_load", duty_load, 0);
    check("accept_done", done, 0);

    for (int idx = 0; idx < seq.size(); idx++) begin
      if (abort_at != 0 && idx == abort_at) begin
        $display("fade tgt=%0d stp=%0d: abandoned at duty=%0d", tgt, stp, duty);
        return;
      end
      for (int i = 0; i < gap - 1; i++) begin
        // A competing command during the ramp must be held off.
        cfg_if.cfg_valid  = 1'($urandom_range(0, 1));
        cfg_if.cfg_target = DW'($urandom);
        tick();
      end
      if (gap > 1) begin
        check("gap_duty_stable", duty, model_duty);
        check("gap_load", duty_load, 0);
        check("gap_ready", cfg_if.cfg_ready, 0);
      end
      cfg_if.cfg_valid = 1'b0;
      pwm_cyc_end      = 1'b1;
      tick();
      pwm_cyc_end = 1'b0;
      model_duty  = seq[idx];
      last        = (idx == seq.size() - 1);
      check("step_duty", duty, model_duty);
      check("step_load", duty_load, 1);
      check("step_done", done, 32'(last));
      check("step_busy", busy, 32'(!last));
      check("step_ready", cfg_if.cfg_ready, 32'(last));
    end
    tick();
    check("post_done", done, 0);
    check("post_load", duty_load, 0);
    check("post_duty", duty, model_duty);
    $display("fade tgt=%0d stp=%0d: %0d steps, final duty=%0d", tgt, stp, seq.size(), duty);
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_target = '0;
    cfg_if.cfg_step   = '0;

    // Reset held for a few cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", cfg_if.cfg_ready, 0);
    check("rst_duty", duty, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_duty", duty, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", cfg_if.cfg_ready, 1);
      check("idle_done", done, 0);
      check("idle_load", duty_load, 0);
    end
    $display("reset/idle: duty=%0d ready=%0d", duty, cfg_if.cfg_ready);

    // Directed fades.
    run_fade(20, 5, 100, 1'b0, 0);
    run_fade(3, 8, 100, 1'b0, 0);
    run_fade(10, 5, 20, 1'b0, 0);
    run_fade(150, 0, 2, 1'b0, 0);
    run_fade(model_duty, 7, 3, 1'b0, 0);
    run_fade(30, 200, 3, 1'b1, 0);
    run_fade(100, 255, 2, 1'b0, 0);
    run_fade(0, 255, 1, 1'b1, 0);

    // Reset in the middle of a ramp at duty=40.
    run_fade(80, 10, 5, 1'b0, 4);
    check("pre_rst_duty", duty, 40);
    rst = 1'b1;
    #1;
    check("midrst_ready", cfg_if.cfg_ready, 0);
    tick();
    check("midrst_duty", duty, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_load", duty_load, 0);
    rst = 1'b0;
    model_duty = 0;
    tick();
    check("post_rst_ready", cfg_if.cfg_ready, 1);
    $display("mid-ramp reset: duty=%0d busy=%0d", duty, busy);

    // Randomized fades.
    for (int r = 0; r < 8; r++) begin
      run_fade(int'($urandom_range(0, 160)), int'($urandom_range(0, 40)),
               int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Duty-cycle sequencer that drives the duty (on-time) input of a PWM generator.
- Accepts fade commands (target duty, step size) over a valid/ready handshake.
- Ramps its duty output toward the target by one step per PWM period, using the generator's period-boundary pulse.
- Gives software or upstream logic smooth brightness/speed transitions without per-period writes.

Parameters:
- PERIOD, 100, PWM period in clocks; maximum legal duty value.
- DW, 8, width of duty/target; must satisfy 2^DW > PERIOD.
- STEP_W, 8, width of step field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  fade command valid.
- cfg_ready  out  1  controller can accept a command.
- cfg_target  in  DW  requested final duty.
- cfg_step  in  STEP_W  duty increment/decrement per PWM period.
- pwm_cyc_end  in  1  single-cycle pulse from the PWM generator at each period boundary.
- duty  out  DW  current duty to the PWM generator (registered).
- duty_load  out  1  pulses 1 cycle in the same cycle a new duty value is first visible.
- busy  out  1  ramp in progress.
- done  out  1  pulses 1 cycle when the fade completes.

Behaviour:
- Reset (clk, rst synchronous active-high):
  - duty=0, duty_load=0, busy=0, done=0, state=IDLE.
  - cfg_ready=0 while rst is high.
  - Reset mid-ramp abandons the command; duty=0 the cycle after rst is sampled.
- States: IDLE, RAMP_UP, RAMP_DN.
- cfg_ready = (state==IDLE) && !rst, combinational.
- IDLE:
  - On cfg_valid&&cfg_ready, latch tgt = min(cfg_target, PERIOD) and stp = (cfg_step==0) ? 1 : cfg_step.
  - Next state: RAMP_UP if tgt>duty; RAMP_DN if tgt<duty.
  - If tgt==duty: stay IDLE, pulse done next cycle, no duty_load.
  - pwm_cyc_end is ignored in IDLE, including in the accept cycle.
- RAMP_UP / RAMP_DN:
  - busy=1 and cfg_ready=0; cfg_valid is ignored (command held off, not dropped).
  - On each pwm_cyc_end, register the new duty and pulse duty_load in that same cycle.
  - RAMP_UP: duty_next = (duty+stp >= tgt) ? tgt : duty+stp. Compute in DW+1 bits; no wrap.
  - RAMP_DN: duty_next = (duty <= tgt+stp) ? tgt : duty-stp. Never underflows below tgt.
  - When duty_next==tgt: go to IDLE with busy=0, and done=1 in the same cycle as the final duty_load.
- Latency: first duty change occurs at the first pwm_cyc_end strictly after the accept cycle.
- Steps to complete = ceil(|tgt-duty_start|/stp) PWM periods.
- duty only changes on pwm_cyc_end, so the generator always sees a stable value within a period.
- done and duty_load never assert in the same cycle except on the final step.

Optional Feature:
- Macro: PWM_FADE_BREATHE_EN.
- With the macro, when RAMP_UP reaches tgt and tgt>0:
  - Set tgt=0 and go to RAMP_DN, keeping stp.
  - busy stays 1; done pulses only when duty returns to 0.
  - This gives one full up/down "breath" per command.
  - RAMP_DN commands and tgt==0 behave as without the macro.
- Without the macro: the controller stops at tgt as described above.

Test Plan:
- Reset, then idle 10 cycles → duty=0, busy=0, cfg_ready=1, done=0, duty_load never high.
- From duty=0, command target=20 step=5, with pwm_cyc_end every 100 clocks:
  - duty goes 5,10,15,20 on four successive pulses, with duty_load on each.
  - done and busy fall on the 4th pulse; cfg_ready=0 throughout.
- From duty=20, command target=3 step=8 → duty goes 12,4,3; third step clamps to target, done with the final duty_load.
- Edge commands:
  - target=150 (>PERIOD) step=0 → tgt clamps to 100, step becomes 1, 100 pulses to done.
  - target equal to current duty → done pulses 1 cycle later, no duty_load, busy stays 0.
- Simultaneous and mid-operation events:
  - cfg accept in the same cycle as pwm_cyc_end → no duty change that cycle.
  - rst asserted mid-ramp at duty=40 → next cycle duty=0, busy=0, no done.
- With PWM_FADE_BREATHE_EN, target=10 step=5 → duty goes 5,10,5,0; single done at 0; busy high throughout.
